// File: rtl/issue_ctrl_unit_if.sv
// Issue control unit bus: decode-side offer, execute-side output register,
// writeback retire port and pending-write count.
// With ISSUE_CTRL_BRANCH_EN defined the bus also carries flush and is_branch.
interface issue_ctrl_unit_if #(
  parameter int REG_ADDR_W = 5
);
  // decode side
  logic                  in_valid;
  logic                  in_ready;
  logic [6:0]            opcode;
  logic [REG_ADDR_W-1:0] rs1;
  logic [REG_ADDR_W-1:0] rs2;
  logic [REG_ADDR_W-1:0] rd;
  // execute side
  logic                  out_valid;
  logic                  out_ready;
  logic                  rs1_re;
  logic                  rs2_re;
  logic                  rd_we;
  logic                  mem_re;
  logic                  mem_we;
  logic                  illegal;
  logic [REG_ADDR_W-1:0] out_rd;
  // writeback side
  logic                  wb_valid;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [3:0]            inflight;
`ifdef ISSUE_CTRL_BRANCH_EN
  logic                  flush;
  logic                  is_branch;

  modport master (
    output in_valid, opcode, rs1, rs2, rd, out_ready, wb_valid, wb_rd, flush,
    input  in_ready, out_valid, rs1_re, rs2_re, rd_we, mem_re, mem_we, illegal,
           out_rd, inflight, is_branch
  );

  modport slave (
    input  in_valid, opcode, rs1, rs2, rd, out_ready, wb_valid, wb_rd, flush,
    output in_ready, out_valid, rs1_re, rs2_re, rd_we, mem_re, mem_we, illegal,
           out_rd, inflight, is_branch
  );
`else
  modport master (
    output in_valid, opcode, rs1, rs2, rd, out_ready, wb_valid, wb_rd,
    input  in_ready, out_valid, rs1_re, rs2_re, rd_we, mem_re, mem_we, illegal,
           out_rd, inflight
  );

  modport slave (
    input  in_valid, opcode, rs1, rs2, rd, out_ready, wb_valid, wb_rd,
    output in_ready, out_valid, rs1_re, rs2_re, rd_we, mem_re, mem_we, illegal,
           out_rd, inflight
  );
`endif
endinterface

// File: rtl/issue_ctrl_unit.sv
// Issue control unit: decodes the offered instruction, stalls it on RAW/WAW
// hazards against a per-register pending-write scoreboard or when the
// in-flight write budget is exhausted, and hands accepted instructions to a
// single output register with a valid/ready handshake.
// Optional feature macro: ISSUE_CTRL_BRANCH_EN (branch/jump decode, flush
// input, is_branch output).
module issue_ctrl_unit #(
  parameter int REG_NUM      = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic              clk,
  input  logic              rst,
  issue_ctrl_unit_if.slave  bus
);

  localparam int         ADDR_SPACE = 1 << REG_ADDR_W;
  localparam logic [3:0] MAX_CNT    = 4'(MAX_INFLIGHT);

  // decoded controls of the offered instruction
  logic dec_rs1_re, dec_rs2_re, dec_rd_we, dec_mem_re, dec_mem_we, dec_illegal;
`ifdef ISSUE_CTRL_BRANCH_EN
  logic dec_branch;
`endif

  // output register
  logic                  out_valid_q;
  logic                  rs1_re_q, rs2_re_q, rd_we_q, mem_re_q, mem_we_q, illegal_q;
  logic [REG_ADDR_W-1:0] out_rd_q;
`ifdef ISSUE_CTRL_BRANCH_EN
  logic                  is_branch_q;
`endif

  // scoreboard: one bit per address, bits for r0 and r>=REG_NUM tied to zero
  logic [ADDR_SPACE-1:0] pend_q, pend_d;
  logic [ADDR_SPACE-1:0] pend_eff;
  logic [ADDR_SPACE-1:0] set_vec, wb_clr_vec, fl_clr_vec;
  logic [3:0]            inflight_q, inflight_d;

  logic wb_ret;     // writeback that actually retires a pending write
  logic fl_ret;     // flush that drops the held entry's pending write
  logic writes_rd;  // offered instruction writes a real register
  logic hazard, full, in_ready, issue, do_set, out_clear;

  // opcode table; anything not listed is illegal and enables nothing
  always_comb begin
    dec_rs1_re  = 1'b0;
    dec_rs2_re  = 1'b0;
    dec_rd_we   = 1'b0;
    dec_mem_re  = 1'b0;
    dec_mem_we  = 1'b0;
    dec_illegal = 1'b0;
`ifdef ISSUE_CTRL_BRANCH_EN
    dec_branch  = 1'b0;
`endif
    case (bus.opcode)
      7'b0010011: begin dec_rs1_re = 1'b1; dec_rd_we = 1'b1; end
      7'b0110011: begin dec_rs1_re = 1'b1; dec_rs2_re = 1'b1; dec_rd_we = 1'b1; end
      7'b0110111,
      7'b0010111: dec_rd_we = 1'b1;
      7'b0000011: begin dec_rs1_re = 1'b1; dec_rd_we = 1'b1; dec_mem_re = 1'b1; end
      7'b0100011: begin dec_rs1_re = 1'b1; dec_rs2_re = 1'b1; dec_mem_we = 1'b1; end
`ifdef ISSUE_CTRL_BRANCH_EN
      7'b1100011: begin dec_rs1_re = 1'b1; dec_rs2_re = 1'b1; dec_branch = 1'b1; end
      7'b1101111: begin dec_rd_we = 1'b1; dec_branch = 1'b1; end
      7'b1100111: begin dec_rs1_re = 1'b1; dec_rd_we = 1'b1; dec_branch = 1'b1; end
`endif
      default:    dec_illegal = 1'b1;
    endcase
  end

  assign wb_ret     = bus.wb_valid & pend_q[bus.wb_rd];
  assign wb_clr_vec = ADDR_SPACE'(wb_ret) << bus.wb_rd;
  // a register being retired this cycle no longer blocks a reader or writer
  assign pend_eff   = pend_q & ~wb_clr_vec;

  assign writes_rd = dec_rd_we & (|bus.rd);
  // RAW on either source, or WAW on the destination
  assign hazard = (dec_rs1_re & pend_eff[bus.rs1]) |
                  (dec_rs2_re & pend_eff[bus.rs2]) |
                  (writes_rd  & pend_eff[bus.rd]);
  // a writeback that retires nothing frees no slot, so only wb_ret relieves full
  assign full   = (inflight_q == MAX_CNT) & writes_rd & ~wb_ret;

`ifdef ISSUE_CTRL_BRANCH_EN
  assign in_ready  = (~out_valid_q | bus.out_ready) & ~hazard & ~full & ~bus.flush;
  assign out_clear = bus.out_ready | bus.flush;
  assign fl_ret    = bus.flush & out_valid_q & rd_we_q & (|out_rd_q) &
                     pend_q[out_rd_q] & ~(wb_ret & (bus.wb_rd == out_rd_q));
`else
  assign in_ready  = (~out_valid_q | bus.out_ready) & ~hazard & ~full;
  assign out_clear = bus.out_ready;
  assign fl_ret    = 1'b0;
`endif

  assign issue      = bus.in_valid & in_ready;
  assign do_set     = issue & writes_rd;
  assign set_vec    = ADDR_SPACE'(do_set) << bus.rd;
  assign fl_clr_vec = ADDR_SPACE'(fl_ret) << out_rd_q;

  // per-register next state: a same-cycle set beats any clear
  for (genvar gi = 0; gi < ADDR_SPACE; gi++) begin : g_pend
    if (gi == 0 || gi >= REG_NUM) begin : g_tied
      assign pend_d[gi] = 1'b0;
    end else begin : g_live
      assign pend_d[gi] = set_vec[gi] | (pend_q[gi] & ~wb_clr_vec[gi] & ~fl_clr_vec[gi]);
    end
  end

  // set and retire of the same register in one cycle nets to no change
  assign inflight_d = inflight_q + 4'(do_set) - 4'(wb_ret) - 4'(fl_ret);

  // scoreboard and pending-write count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q     <= '0;
      inflight_q <= '0;
    end else begin
      pend_q     <= pend_d;
      inflight_q <= inflight_d;
    end
  end

  // output register: load on issue, hold while stalled, drop valid when consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      rs1_re_q    <= 1'b0;
      rs2_re_q    <= 1'b0;
      rd_we_q     <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      illegal_q   <= 1'b0;
      out_rd_q    <= '0;
`ifdef ISSUE_CTRL_BRANCH_EN
      is_branch_q <= 1'b0;
`endif
    end else if (issue) begin
      out_valid_q <= 1'b1;
      rs1_re_q    <= dec_rs1_re;
      rs2_re_q    <= dec_rs2_re;
      rd_we_q     <= dec_rd_we;
      mem_re_q    <= dec_mem_re;
      mem_we_q    <= dec_mem_we;
      illegal_q   <= dec_illegal;
      out_rd_q    <= bus.rd;
`ifdef ISSUE_CTRL_BRANCH_EN
      is_branch_q <= dec_branch;
`endif
    end else if (out_clear) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.rs1_re    = rs1_re_q;
  assign bus.rs2_re    = rs2_re_q;
  assign bus.rd_we     = rd_we_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.illegal   = illegal_q;
  assign bus.out_rd    = out_rd_q;
  assign bus.inflight  = inflight_q;
`ifdef ISSUE_CTRL_BRANCH_EN
  assign bus.is_branch = is_branch_q;
`endif

endmodule

// File: tb/tb_issue_ctrl_unit.sv
// Testbench for issue_ctrl_unit (default build): directed scenarios followed
// by randomized traffic, all checked against a scoreboard model kept here.
module tb_issue_ctrl_unit;
  localparam int REG_NUM = 32;
  localparam int AW      = 5;
  localparam int MAXI    = 4;

  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_ADD  = 7'b0110011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  issue_ctrl_unit_if #(.REG_ADDR_W(AW)) bus();

  issue_ctrl_unit #(
    .REG_NUM(REG_NUM), .REG_ADDR_W(AW), .MAX_INFLIGHT(MAXI)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int    vectors_applied;
  int    miscompares;
  string phase;

  // model state: set of pending registers and the held output entry
  bit          pend_m [REG_NUM];
  bit          ov_m;
  bit [5:0]    ctl_m;   // {rs1_re, rs2_re, rd_we, mem_re, mem_we, illegal}
  logic [AW-1:0] ord_m;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors_applied++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s [%s] got %0h expected %0h at %0t", tag, phase, obs, exp, $time);
    end
  endtask

  // opcode table from the instruction set description
  function automatic bit [5:0] decode_m(input logic [6:0] op);
    case (op)
      7'b0010011: return 6'b101000;
      7'b0110011: return 6'b111000;
      7'b0110111: return 6'b001000;
      7'b0010111: return 6'b001000;
      7'b0000011: return 6'b101100;
      7'b0100011: return 6'b110010;
      default:    return 6'b000001;
    endcase
  endfunction

  function automatic int count_pend();
    int n = 0;
    for (int r = 0; r < REG_NUM; r++) n += int'(pend_m[r]);
    return n;
  endfunction

  function automatic bit blocked(input logic [AW-1:0] r, input bit wbret, input logic [AW-1:0] wrd);
    return (r != 0) && pend_m[r] && !(wbret && wrd == r);
  endfunction

  task automatic drive(input bit v, input logic [6:0] op, input logic [AW-1:0] r1,
                       input logic [AW-1:0] r2, input logic [AW-1:0] d, input bit ordy,
                       input bit wv, input logic [AW-1:0] wrd);
    bus.in_valid  = v;
    bus.opcode    = op;
    bus.rs1       = r1;
    bus.rs2       = r2;
    bus.rd        = d;
    bus.out_ready = ordy;
    bus.wb_valid  = wv;
    bus.wb_rd     = wrd;
  endtask

  task automatic clear_model();
    for (int r = 0; r < REG_NUM; r++) pend_m[r] = 1'b0;
    ov_m  = 1'b0;
    ctl_m = '0;
    ord_m = '0;
  endtask

  task automatic check_outputs();
    check_val("out_valid", {31'b0, bus.out_valid}, {31'b0, ov_m});
    check_val("inflight", {28'b0, bus.inflight}, 32'(count_pend()));
    if (ov_m) begin
      check_val("ctl", {26'b0, bus.rs1_re, bus.rs2_re, bus.rd_we, bus.mem_re, bus.mem_we, bus.illegal},
                {26'b0, ctl_m});
      check_val("out_rd", {27'b0, bus.out_rd}, {27'b0, ord_m});
    end
  endtask

  task automatic check_all_zero();
    check_val("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check_val("rst_ctl", {26'b0, bus.rs1_re, bus.rs2_re, bus.rd_we, bus.mem_re, bus.mem_we, bus.illegal}, 32'd0);
    check_val("rst_out_rd", {27'b0, bus.out_rd}, 32'd0);
    check_val("rst_inflight", {28'b0, bus.inflight}, 32'd0);
  endtask

  // one clock cycle with the inputs currently driven
  task automatic step();
    bit [5:0] dec;
    bit wbret, wr, haz, full, rdy, iss;
    logic [AW-1:0] wrd, d;
    #2;
    dec   = decode_m(bus.opcode);
    wrd   = bus.wb_rd;
    d     = bus.rd;
    wbret = bus.wb_valid && wrd != 0 && pend_m[wrd];
    wr    = dec[3] && d != 0;
    haz   = (dec[5] && blocked(bus.rs1, wbret, wrd)) ||
            (dec[4] && blocked(bus.rs2, wbret, wrd)) ||
            (wr && blocked(d, wbret, wrd));
    full  = (count_pend() == MAXI) && wr && !wbret;
    rdy   = (!ov_m || bus.out_ready) && !haz && !full;
    check_val("in_ready", {31'b0, bus.in_ready}, {31'b0, rdy});
    iss   = bus.in_valid && rdy;
    @(posedge clk);
    if (wbret) pend_m[wrd] = 1'b0;
    if (iss && wr) pend_m[d] = 1'b1;
    if (iss) begin
      ov_m  = 1'b1;
      ctl_m = dec;
      ord_m = d;
    end else if (bus.out_ready) begin
      ov_m = 1'b0;
    end
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 7'd0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_all_zero();
    clear_model();
    rst = 1'b0;
  endtask

  logic [6:0] ops [8];
  int         cand [$];

  initial begin
    vectors_applied = 0;
    miscompares     = 0;
    ops = '{7'b0010011, 7'b0110011, 7'b0110111, 7'b0010111,
            7'b0000011, 7'b0100011, 7'b1111111, 7'b1100011};

    phase = "reset";
    do_reset();

    // ADDI rd=5 issues, one write pending
    phase = "addi";
    drive(1, OP_ADDI, 0, 0, 5, 1, 0, 0);
    step();

    // ADD reading r5 stalls until r5 is retired, then goes in the retire cycle
    phase = "raw";
    drive(1, OP_ADD, 5, 0, 3, 1, 0, 0);
    step();
    step();
    check_val("raw_stall", {31'b0, bus.in_ready}, 32'd0);
    drive(1, OP_ADD, 5, 0, 3, 1, 1, 5);
    step();
    drive(0, OP_ADD, 0, 0, 0, 1, 1, 3);
    step();

    // four loads fill the budget; a fifth write stalls, a store still issues
    phase = "full";
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      drive(1, OP_LW, 0, 0, AW'(i), 1, 0, 0);
      step();
    end
    drive(1, OP_LW, 0, 0, 5, 1, 0, 0);
    step();
    step();
    check_val("full_stall", {31'b0, bus.in_ready}, 32'd0);
    drive(1, OP_SW, 0, 0, 0, 1, 0, 0);
    step();

    // back-pressure: held entry stays put for three cycles, then drains
    phase = "hold";
    do_reset();
    drive(1, OP_ADDI, 0, 0, 9, 0, 0, 0);
    step();
    drive(1, OP_ADD, 0, 0, 10, 0, 0, 0);
    repeat (3) step();
    check_val("hold_rd", {27'b0, bus.out_rd}, 32'd9);
    drive(1, OP_ADD, 0, 0, 10, 1, 0, 0);
    step();
    check_val("hold_release_rd", {27'b0, bus.out_rd}, 32'd10);

    // same-cycle re-issue and retire of r7: still pending, count unchanged
    phase = "set_wins";
    do_reset();
    drive(1, OP_ADDI, 0, 0, 7, 1, 0, 0);
    step();
    drive(1, OP_ADDI, 0, 0, 7, 1, 1, 7);
    step();
    check_val("set_wins_inflight", {28'b0, bus.inflight}, 32'd1);
    drive(1, OP_ADD, 7, 0, 0, 1, 0, 0);
    step();

    // illegal opcode issues with enables clear and no scoreboard change
    phase = "illegal";
    drive(1, 7'b1111111, 0, 0, 6, 1, 0, 0);
    step();
    check_val("illegal_bit", {31'b0, bus.illegal}, 32'd1);

    // reset asserted mid-stall clears everything without waiting for a clock
    phase = "rst_mid";
    drive(1, OP_ADDI, 0, 0, 2, 0, 0, 0);
    step();
    drive(1, OP_ADDI, 0, 0, 3, 0, 0, 0);
    step();
    #2;
    rst = 1'b1;
    #1;
    check_all_zero();
    clear_model();
    check_val("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    step();

    // randomized traffic
    phase = "random";
    do_reset();
    for (int n = 0; n < 600; n++) begin
      bit wv;
      logic [AW-1:0] wrd;
      cand.delete();
      for (int r = 1; r < REG_NUM; r++) if (pend_m[r]) cand.push_back(r);
      wv  = ($urandom_range(0, 9) < 4);
      if (cand.size() != 0 && $urandom_range(0, 3) != 0)
        wrd = AW'(cand[$urandom_range(0, cand.size() - 1)]);
      else
        wrd = AW'($urandom_range(0, 7));
      drive($urandom_range(0, 9) < 7, ops[$urandom_range(0, 7)],
            AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
            $urandom_range(0, 9) < 7, wv, wrd);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

  // absolute time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout [%s] got running expected finished", phase);
    $fatal(1, "timeout");
  end

endmodule
